perceptron_trainer: RTL and testbench

Online training engine for the 8-input perceptron predictor. It holds the weight and bias registers and scores each labelled sample sequentially. When a sample is mispredicted or scored inside the margin, it applies the fixed-step perceptron update. The packed weight and bias outputs feed the combinational predictor directly, so the trainer writes the weights that the predictor reads.

---
 rtl/perceptron_trainer_if.sv | 27 ++
 rtl/perceptron_trainer.sv | 158 +++++++++++++++
 tb/tb_perceptron_trainer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_trainer_if.sv
// Sample/result bus between a sample source and the perceptron trainer.
// The packed weights and bias are carried here too, since the predictor reads them directly.
interface perceptron_trainer_if #(
  parameter int WIDTH = 10
);
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             x;
  logic                   label;
  logic                   train_en;
  logic                   done;
  logic                   predict;
  logic                   trained;
  logic [8*WIDTH-1:0]     weights;
  logic [WIDTH-1:0]       bias;
  logic [15:0]            err_cnt;

  modport master (
    output in_valid, x, label, train_en,
    input  in_ready, done, predict, trained, weights, bias, err_cnt
  );

  modport slave (
    input  in_valid, x, label, train_en,
    output in_ready, done, predict, trained, weights, bias, err_cnt
  );
endinterface

// File: rtl/perceptron_trainer.sv
// Online perceptron trainer: scores one sample over 8 accumulate cycles, then applies a
// saturating fixed-step update when the sample is mispredicted or falls inside the margin.
module perceptron_trainer #(
  parameter int WIDTH     = 10,
  parameter int STEP      = 16,
  parameter int THETA     = 64,
  parameter int INIT_W    = 0,
  parameter int INIT_BIAS = 0
) (
  input logic            clk,
  input logic            rst_n,
  perceptron_trainer_if.slave bus
);

  localparam int ACC_W = WIDTH + 4;
  localparam int EXT_W = WIDTH + 2;

  localparam logic signed [EXT_W-1:0] WMAX_E  = EXT_W'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] WMIN_E  = EXT_W'(-(2 ** (WIDTH - 1)));
  localparam logic signed [EXT_W-1:0] STEP_E  = EXT_W'(STEP);
  localparam logic signed [ACC_W-1:0] THETA_A = ACC_W'(THETA);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_EVAL,
    S_UPDATE
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  logic [7:0]              r_x;
  logic                    r_label;
  logic                    r_train_en;
  logic signed [ACC_W-1:0] r_acc;
  logic [2:0]              r_idx;
  logic signed [WIDTH-1:0] r_w [8];
  logic signed [WIDTH-1:0] r_bias;
  logic                    r_done;
  logic                    r_predict;
  logic                    r_trained;
  logic [15:0]             r_err_cnt;

  logic                    w_in_ready;
  logic                    w_accept;
  logic signed [ACC_W-1:0] w_term;
  logic                    w_predict;
  logic                    w_miss;
  logic                    w_margin;
  logic                    w_train;
  logic [8*WIDTH-1:0]      w_weights;

  // Widen by two bits so v +/- STEP cannot wrap before the clamp.
  function automatic logic signed [WIDTH-1:0] sat_step(input logic signed [WIDTH-1:0] v,
                                                       input logic up);
    logic signed [EXT_W-1:0] s;
    s = EXT_W'(v) + (up ? STEP_E : -STEP_E);
    if (s > WMAX_E) return WMAX_E[WIDTH-1:0];
    if (s < WMIN_E) return WMIN_E[WIDTH-1:0];
    return s[WIDTH-1:0];
  endfunction

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next_state = S_ACCUM;
      S_ACCUM:  if (r_idx == 3'd7) w_next_state = S_EVAL;
      S_EVAL:   w_next_state = w_train ? S_UPDATE : S_IDLE;
      S_UPDATE: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    w_in_ready = (r_state == S_IDLE);
    w_accept   = w_in_ready && bus.in_valid;
    w_term     = r_x[r_idx] ? ACC_W'(r_w[r_idx]) : '0;
    w_predict  = !r_acc[ACC_W-1];
    w_miss     = (w_predict != r_label);
    w_margin   = (r_acc >= -THETA_A) && (r_acc <= THETA_A);
    w_train    = r_train_en && (w_miss || w_margin);
  end

  // NOTE: the weight array is reset explicitly because the predictor consumes it directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_w[i] <= WIDTH'(INIT_W);
      r_bias     <= WIDTH'(INIT_BIAS);
      r_done     <= 1'b0;
      r_predict  <= 1'b0;
      r_trained  <= 1'b0;
      r_err_cnt  <= '0;
      r_x        <= '0;
      r_label    <= 1'b0;
      r_train_en <= 1'b0;
      r_acc      <= '0;
      r_idx      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x        <= bus.x;
            r_label    <= bus.label;
            r_train_en <= bus.train_en;
            r_acc      <= ACC_W'(r_bias);
            r_idx      <= '0;
          end
        end
        S_ACCUM: begin
          r_acc <= r_acc + w_term;
          r_idx <= r_idx + 3'd1;
        end
        S_EVAL: begin
          r_predict <= w_predict;
          if (w_miss && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
          if (!w_train) begin
            r_done    <= 1'b1;
            r_trained <= 1'b0;
          end
        end
        S_UPDATE: begin
          for (int i = 0; i < 8; i++) begin
            if (r_x[i]) r_w[i] <= sat_step(r_w[i], r_label);
          end
          r_bias    <= sat_step(r_bias, r_label);
          r_done    <= 1'b1;
          r_trained <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_weights = '0;
    for (int i = 0; i < 8; i++) w_weights[i*WIDTH +: WIDTH] = r_w[i];
  end

  assign bus.in_ready = w_in_ready;
  assign bus.done     = r_done;
  assign bus.predict  = r_predict;
  assign bus.trained  = r_trained;
  assign bus.weights  = w_weights;
  assign bus.bias     = r_bias;
  assign bus.err_cnt  = r_err_cnt;

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n) r_done |=> !r_done);

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench: two trainers (default margin and a wide margin for saturation), driven
// by directed and random samples, checked against an integer perceptron model.
module tb_perceptron_trainer;
  localparam int WIDTH   = 10;
  localparam int STEP    = 16;
  localparam int THETA_A = 64;
  localparam int THETA_S = 4000;
  localparam int WMAX    = 511;
  localparam int WMIN    = -512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  perceptron_trainer_if #(.WIDTH(WIDTH)) bus_a ();
  perceptron_trainer_if #(.WIDTH(WIDTH)) bus_s ();

  perceptron_trainer #(.WIDTH(WIDTH), .STEP(STEP), .THETA(THETA_A), .INIT_W(0), .INIT_BIAS(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  perceptron_trainer #(.WIDTH(WIDTH), .STEP(STEP), .THETA(THETA_S), .INIT_W(0), .INIT_BIAS(0))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s.slave));

  typedef struct {
    logic               p;
    logic               t;
    logic [15:0]        err;
    logic [8*WIDTH-1:0] w;
    logic [WIDTH-1:0]   b;
    int                 acc_cyc;
    int                 lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_s[$];

  int n_checks = 0;
  int n_fail   = 0;

  int mw[2][8];
  int mb[2];
  int merr[2];

  logic [8*WIDTH-1:0] hold_w[2];
  logic [WIDTH-1:0]   hold_b[2];
  logic               hold_p[2];
  logic               hold_t[2];
  logic [15:0]        hold_e[2];
  int                 last_done[2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int sat(input int v);
    if (v > WMAX) return WMAX;
    if (v < WMIN) return WMIN;
    return v;
  endfunction

  function automatic logic [8*WIDTH-1:0] pack_w(input int k);
    logic [8*WIDTH-1:0] r;
    for (int i = 0; i < 8; i++) r[i*WIDTH +: WIDTH] = WIDTH'(mw[k][i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mw[k][i] = 0;
      mb[k] = 0;
      merr[k] = 0;
      hold_w[k] = '0;
      hold_b[k] = '0;
      hold_p[k] = 1'b0;
      hold_t[k] = 1'b0;
      hold_e[k] = '0;
    end
    q_a.delete();
    q_s.delete();
  endtask

  // Reference: score with the current weights, then apply the perceptron rule.
  task automatic model_issue(input int k, input logic [7:0] x, input logic lbl,
                             input logic te, input int acc_cyc);
    int   acc, theta;
    logic p, miss, tr;
    exp_t e;
    acc = mb[k];
    for (int i = 0; i < 8; i++) if (x[i]) acc += mw[k][i];
    theta = (k == 0) ? THETA_A : THETA_S;
    p    = (acc >= 0);
    miss = (p != lbl);
    tr   = te && (miss || (acc >= -theta && acc <= theta));
    if (miss && merr[k] < 65535) merr[k]++;
    if (tr) begin
      for (int i = 0; i < 8; i++) if (x[i]) mw[k][i] = sat(mw[k][i] + (lbl ? STEP : -STEP));
      mb[k] = sat(mb[k] + (lbl ? STEP : -STEP));
    end
    e.p = p;
    e.t = tr;
    e.err = 16'(merr[k]);
    e.w = pack_w(k);
    e.b = WIDTH'(mb[k]);
    e.acc_cyc = acc_cyc;
    e.lat = tr ? 10 : 9;  // done rises on E9 (score only) or E10 (update)
    if (k == 0) q_a.push_back(e);
    else        q_s.push_back(e);
  endtask

  task automatic mon_step(input int k, input logic done, input logic rdy, input logic p,
                          input logic t, input logic [15:0] err,
                          input logic [8*WIDTH-1:0] w, input logic [WIDTH-1:0] b);
    exp_t e;
    int   qn;
    if (!rst_n) return;
    qn = (k == 0) ? q_a.size() : q_s.size();
    if (done) begin
      if (qn == 0) begin
        check($sformatf("dut%0d_spurious_done", k), done, 1'b0);
      end else begin
        e = (k == 0) ? q_a.pop_front() : q_s.pop_front();
        check($sformatf("dut%0d_predict", k), p, e.p);
        check($sformatf("dut%0d_trained", k), t, e.t);
        check($sformatf("dut%0d_err_cnt", k), err, e.err);
        check($sformatf("dut%0d_weights", k), w, e.w);
        check($sformatf("dut%0d_bias", k), b, e.b);
        check($sformatf("dut%0d_latency", k), cyc - e.acc_cyc, e.lat);
        hold_w[k] = e.w;
        hold_b[k] = e.b;
        hold_p[k] = e.p;
        hold_t[k] = e.t;
        hold_e[k] = e.err;
        last_done[k] = cyc;
      end
    end else begin
      check($sformatf("dut%0d_weights_stable", k), w, hold_w[k]);
      check($sformatf("dut%0d_bias_stable", k), b, hold_b[k]);
      if (rdy) begin
        check($sformatf("dut%0d_predict_hold", k), p, hold_p[k]);
        check($sformatf("dut%0d_trained_hold", k), t, hold_t[k]);
        check($sformatf("dut%0d_err_hold", k), err, hold_e[k]);
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, bus_a.done, bus_a.in_ready, bus_a.predict, bus_a.trained, bus_a.err_cnt,
             bus_a.weights, bus_a.bias);
    mon_step(1, bus_s.done, bus_s.in_ready, bus_s.predict, bus_s.trained, bus_s.err_cnt,
             bus_s.weights, bus_s.bias);
  end

  // Called at a negedge; returns at the negedge after the acceptance edge with in_valid still high.
  task automatic send(input int k, input logic [7:0] x, input logic lbl, input logic te);
    int n = 0;
    if (k == 0) begin
      bus_s.in_valid = 1'b0;
      bus_a.in_valid = 1'b1; bus_a.x = x; bus_a.label = lbl; bus_a.train_en = te;
    end else begin
      bus_a.in_valid = 1'b0;
      bus_s.in_valid = 1'b1; bus_s.x = x; bus_s.label = lbl; bus_s.train_en = te;
    end
    while (!((k == 0) ? bus_a.in_ready : bus_s.in_ready)) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        check("accept_timeout", 1'b0, 1'b1);
        return;
      end
    end
    model_issue(k, x, lbl, te, cyc + 1);
    @(negedge clk);
  endtask

  task automatic release_valid();
    bus_a.in_valid = 1'b0;
    bus_s.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q_a.size() != 0 || q_s.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        check("done_timeout", 1'b0, 1'b1);
        q_a.delete();
        q_s.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx;
    logic       rl, rt;
    int         rk;

    bus_a.in_valid = 1'b0; bus_a.x = '0; bus_a.label = 1'b0; bus_a.train_en = 1'b1;
    bus_s.in_valid = 1'b0; bus_s.x = '0; bus_s.label = 1'b0; bus_s.train_en = 1'b1;
    last_done[0] = 0;
    last_done[1] = 0;
    model_reset();

    // Reset defaults
    do_reset(2);
    check("rst_weights", bus_a.weights, '0);
    check("rst_bias", bus_a.bias, '0);
    check("rst_in_ready", bus_a.in_ready, 1'b1);
    check("rst_done", bus_a.done, 1'b0);
    check("rst_predict", bus_a.predict, 1'b0);
    check("rst_trained", bus_a.trained, 1'b0);
    check("rst_err_cnt", bus_a.err_cnt, 16'd0);
    check("rst_s_in_ready", bus_s.in_ready, 1'b1);

    // Margin training: acc=0 is correct but inside the margin
    send(0, 8'h00, 1'b1, 1'b1);
    release_valid();
    wait_idle();
    check("margin_bias", bus_a.bias, 10'd16);
    check("margin_weights", bus_a.weights, '0);
    check("margin_trained", bus_a.trained, 1'b1);
    check("margin_err_cnt", bus_a.err_cnt, 16'd0);

    // Mispredict
    do_reset(1);
    send(0, 8'hFF, 1'b0, 1'b1);
    release_valid();
    wait_idle();
    check("miss_weights", bus_a.weights, {8{10'h3F0}});
    check("miss_bias", bus_a.bias, 10'h3F0);
    check("miss_err_cnt", bus_a.err_cnt, 16'd1);
    check("miss_predict", bus_a.predict, 1'b1);

    // Score only
    do_reset(1);
    send(0, 8'hFF, 1'b0, 1'b0);
    release_valid();
    wait_idle();
    check("score_trained", bus_a.trained, 1'b0);
    check("score_err_cnt", bus_a.err_cnt, 16'd1);
    check("score_weights", bus_a.weights, '0);

    // Saturation with the wide margin, in_valid held across samples
    do_reset(1);
    for (int i = 0; i < 40; i++) begin
      send(1, 8'h01, 1'b1, 1'b1);
      if (i > 0) check("b2b_accept_edge", cyc, last_done[1] + 1);
    end
    release_valid();
    wait_idle();
    check("sat_w0", bus_s.weights[WIDTH-1:0], 10'd511);
    check("sat_w1_7", bus_s.weights[8*WIDTH-1:WIDTH], '0);
    check("sat_bias", bus_s.bias, 10'd511);

    // Reset in the middle of ACCUM
    do_reset(1);
    send(0, 8'h00, 1'b1, 1'b1);
    release_valid();
    wait_idle();
    check("pre_rst_bias", bus_a.bias, 10'd16);
    send(0, 8'hA5, 1'b0, 1'b1);
    release_valid();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_in_ready", bus_a.in_ready, 1'b1);
    check("midrst_done", bus_a.done, 1'b0);
    check("midrst_bias", bus_a.bias, 10'd0);
    check("midrst_err_cnt", bus_a.err_cnt, 16'd0);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    // Random samples to both trainers
    for (int i = 0; i < 80; i++) begin
      rk = int'($urandom_range(0, 1));
      rx = 8'($urandom);
      rl = 1'($urandom);
      rt = ($urandom_range(0, 3) != 0);
      send(rk, rx, rl, rt);
      if ($urandom_range(0, 1) == 1) begin
        release_valid();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    release_valid();
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
